// File: rtl/dbc_multiport_fsm_pkg.sv
// Shared definitions for the multi-port DbC port state machine.
// Holds the 3-bit state encodings, the state width and the watchdog width
// helper used by the per-port FSM and the top.
package dbc_multiport_fsm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF          = 3'd0,
        ST_DISCONNECTED = 3'd1,
        ST_DISABLED     = 3'd2,
        ST_ENABLED      = 3'd3,
        ST_RESETTING    = 3'd4,
        ST_ERROR        = 3'd5,
        ST_CONFIGURED   = 3'd6
    } dbc_state_e;

    // Code 7 is never produced; if it ever shows up the FSM lands here.
    localparam logic [STATE_W-1:0] ST_ILLEGAL_DEFAULT = ST_OFF;

    // Watchdog width: enough bits to reach max(a,b)-1, never narrower than 1.
    function automatic int wd_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/dbc_multiport_fsm_if.sv
// Bus bundle between the port status/change bank, the DbC FSM block and the
// DbC event/doorbell logic.
//   master : status bank side, drives DCE and per-port change/status bits,
//            observes port_state/state_chg/timeout_err/dbc_run.
//   slave  : the FSM block.
// With DBC_EVENT_LATCH_EN defined, evt_clr (W1C) and evt_pending are added.
interface dbc_multiport_fsm_if #(parameter int NUM_PORTS = 2);

    logic                   DCE;
    logic [NUM_PORTS-1:0]   CSC;
    logic [NUM_PORTS-1:0]   PLC;
    logic [NUM_PORTS-1:0]   PRC;
    logic [NUM_PORTS-1:0]   PED;
    logic [NUM_PORTS-1:0]   CEC;
    logic [NUM_PORTS-1:0]   Reset_rcvd;
    logic [NUM_PORTS-1:0]   set_config_succesful;
    logic [NUM_PORTS-1:0]   EnumError;
    logic [NUM_PORTS-1:0]   Deconfigure;
    logic [3*NUM_PORTS-1:0] port_state;
    logic [NUM_PORTS-1:0]   state_chg;
    logic [NUM_PORTS-1:0]   timeout_err;
    logic                   dbc_run;
`ifdef DBC_EVENT_LATCH_EN
    logic [NUM_PORTS-1:0]   evt_clr;
    logic [NUM_PORTS-1:0]   evt_pending;
`endif

    modport master (
        output DCE, CSC, PLC, PRC, PED, CEC, Reset_rcvd,
               set_config_succesful, EnumError, Deconfigure,
`ifdef DBC_EVENT_LATCH_EN
        output evt_clr,
        input  evt_pending,
`endif
        input  port_state, state_chg, timeout_err, dbc_run
    );

    modport slave (
        input  DCE, CSC, PLC, PRC, PED, CEC, Reset_rcvd,
               set_config_succesful, EnumError, Deconfigure,
`ifdef DBC_EVENT_LATCH_EN
        input  evt_clr,
        output evt_pending,
`endif
        output port_state, state_chg, timeout_err, dbc_run
    );

endinterface

// File: rtl/dbc_port_fsm.sv
// One DbC port state machine with its enumeration/reset watchdog.
// Ports: clock, reset_n (async low), dce, per-port change/status inputs,
// state (registered), state_chg (pulse on any transition), timeout_err
// (pulse when the watchdog forced ERROR).
module dbc_port_fsm
    import dbc_multiport_fsm_pkg::*;
#(
    parameter int ENUM_TIMEOUT  = 1024,
    parameter int RESET_TIMEOUT = 256
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               dce,
    input  logic               csc,
    input  logic               plc,
    input  logic               prc,
    input  logic               ped,
    input  logic               cec,
    input  logic               reset_rcvd,
    input  logic               set_cfg,
    input  logic               enum_err,
    input  logic               deconfig,
    output logic [STATE_W-1:0] state,
    output logic               state_chg,
    output logic               timeout_err
);

    localparam int WD_W = wd_width(ENUM_TIMEOUT, RESET_TIMEOUT);
    localparam logic [WD_W-1:0] ENUM_LAST  = WD_W'(ENUM_TIMEOUT - 1);
    localparam logic [WD_W-1:0] RESET_LAST = WD_W'(RESET_TIMEOUT - 1);

    logic [STATE_W-1:0] state_q, nxt;
    logic [WD_W-1:0]    wdog_q;
    logic               expire;

    // Events are checked before the watchdog, so an event in the expiry
    // cycle wins over the timeout.
    always_comb begin
        nxt    = state_q;
        expire = 1'b0;
        if (!dce) begin
            nxt = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:          nxt = ST_DISCONNECTED;
                ST_DISCONNECTED: if (csc) nxt = ST_ENABLED;
                ST_DISABLED: begin
                    if (csc)      nxt = ST_DISCONNECTED;
                    else if (ped) nxt = ST_ENABLED;
                end
                ST_ENABLED: begin
                    if (csc)                  nxt = ST_DISCONNECTED;
                    else if (!ped)            nxt = ST_DISABLED;
                    else if (cec | plc)       nxt = ST_DISABLED;
                    else if (enum_err)        nxt = ST_ERROR;
                    else if (reset_rcvd)      nxt = ST_RESETTING;
                    else if (set_cfg)         nxt = ST_CONFIGURED;
                    else if (wdog_q == ENUM_LAST) begin
                        nxt    = ST_ERROR;
                        expire = 1'b1;
                    end
                end
                ST_RESETTING: begin
                    if (csc)                  nxt = ST_DISCONNECTED;
                    else if (!ped)            nxt = ST_DISABLED;
                    else if (prc)             nxt = ST_ENABLED;
                    else if (wdog_q == RESET_LAST) begin
                        nxt    = ST_ERROR;
                        expire = 1'b1;
                    end
                end
                ST_ERROR: begin
                    if (csc)             nxt = ST_DISCONNECTED;
                    else if (!ped)       nxt = ST_DISABLED;
                    else if (reset_rcvd) nxt = ST_RESETTING;
                end
                ST_CONFIGURED: begin
                    if (csc)             nxt = ST_DISCONNECTED;
                    else if (!ped)       nxt = ST_DISABLED;
                    else if (reset_rcvd) nxt = ST_RESETTING;
                    else if (deconfig)   nxt = ST_ENABLED;
                end
                default:                 nxt = ST_ILLEGAL_DEFAULT;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_OFF;
            state_chg   <= 1'b0;
            timeout_err <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= nxt;
            state_chg   <= (nxt != state_q);
            timeout_err <= expire;
            // Only ENABLED/RESETTING accumulate; any transition restarts.
            if ((nxt != state_q) ||
                ((state_q != ST_ENABLED) && (state_q != ST_RESETTING)))
                wdog_q <= '0;
            else
                wdog_q <= wdog_q + 1'b1;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/dbc_multiport_fsm.sv
// NUM_PORTS independent DbC port FSMs sharing one DbC enable, plus the
// aggregate dbc_run indication.
// Ports: clock, reset_n (async low), bus (slave modport of
// dbc_multiport_fsm_if). Port i state appears at port_state[3i+2:3i].
// Optional DBC_EVENT_LATCH_EN: per-port evt_pending latch, set by state_chg,
// cleared by evt_clr (W1C), set wins.
module dbc_multiport_fsm
    import dbc_multiport_fsm_pkg::*;
#(
    parameter int NUM_PORTS     = 2,
    parameter int ENUM_TIMEOUT  = 1024,
    parameter int RESET_TIMEOUT = 256
) (
    input  logic                clock,
    input  logic                reset_n,
    dbc_multiport_fsm_if.slave  bus
);

    logic [NUM_PORTS-1:0][STATE_W-1:0] state_w;
    logic [NUM_PORTS-1:0]              chg_w;
    logic [NUM_PORTS-1:0]              tmo_w;
    logic                              run_any;
    logic                              run_q;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        dbc_port_fsm #(
            .ENUM_TIMEOUT  (ENUM_TIMEOUT),
            .RESET_TIMEOUT (RESET_TIMEOUT)
        ) u_port (
            .clock       (clock),
            .reset_n     (reset_n),
            .dce         (bus.DCE),
            .csc         (bus.CSC[i]),
            .plc         (bus.PLC[i]),
            .prc         (bus.PRC[i]),
            .ped         (bus.PED[i]),
            .cec         (bus.CEC[i]),
            .reset_rcvd  (bus.Reset_rcvd[i]),
            .set_cfg     (bus.set_config_succesful[i]),
            .enum_err    (bus.EnumError[i]),
            .deconfig    (bus.Deconfigure[i]),
            .state       (state_w[i]),
            .state_chg   (chg_w[i]),
            .timeout_err (tmo_w[i])
        );
    end

    always_comb begin
        run_any = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++)
            run_any = run_any | (state_w[i] == ST_CONFIGURED);
    end

    // Registered from the registered states, so dbc_run trails CONFIGURED
    // by one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) run_q <= 1'b0;
        else          run_q <= run_any;
    end

    assign bus.port_state  = state_w;
    assign bus.state_chg   = chg_w;
    assign bus.timeout_err = tmo_w;
    assign bus.dbc_run     = run_q;

`ifdef DBC_EVENT_LATCH_EN
    logic [NUM_PORTS-1:0] evt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) evt_q <= '0;
        else          evt_q <= (evt_q & ~bus.evt_clr) | chg_w;
    end

    assign bus.evt_pending = evt_q;
`endif

endmodule

// File: tb/tb_dbc_multiport_fsm.sv
// Directed bench for dbc_multiport_fsm: 2 ports, ENUM_TIMEOUT=8,
// RESET_TIMEOUT=4. Inputs change and outputs are sampled on the falling edge.
module tb_dbc_multiport_fsm;

    localparam int NP = 2;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    dbc_multiport_fsm_if #(.NUM_PORTS(NP)) bus();

    dbc_multiport_fsm #(
        .NUM_PORTS     (NP),
        .ENUM_TIMEOUT  (8),
        .RESET_TIMEOUT (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [5:0] ps(input logic [2:0] p1, input logic [2:0] p0);
        return {p1, p0};
    endfunction

    initial begin
        bus.DCE = 1'b0;
        bus.CSC = '0; bus.PLC = '0; bus.PRC = '0; bus.PED = 2'b11;
        bus.CEC = '0; bus.Reset_rcvd = '0; bus.set_config_succesful = '0;
        bus.EnumError = '0; bus.Deconfigure = '0;
`ifdef DBC_EVENT_LATCH_EN
        bus.evt_clr = '0;
`endif
        step(2);
        chk("rst_state", 32'(bus.port_state), 32'(ps(0, 0)));
        chk("rst_chg",   32'(bus.state_chg), 0);
        chk("rst_tmo",   32'(bus.timeout_err), 0);
        chk("rst_run",   32'(bus.dbc_run), 0);

        // Enable: both ports OFF -> DISCONNECTED
        reset_n = 1'b1;
        bus.DCE = 1'b1;
        step(1);
        chk("dce_state", 32'(bus.port_state), 32'(ps(1, 1)));
        chk("dce_chg",   32'(bus.state_chg), 32'h3);
        step(1);
        chk("dce_chg_off", 32'(bus.state_chg), 0);
`ifdef DBC_EVENT_LATCH_EN
        chk("evt_set", 32'(bus.evt_pending), 32'h3);
        bus.evt_clr = 2'b11;
        step(1);
        chk("evt_clr", 32'(bus.evt_pending), 0);
        bus.evt_clr = 2'b00;
`endif

        // Port0: CSC -> ENABLED, then SET_CONFIGURATION -> CONFIGURED
        bus.CSC = 2'b01;
        step(1);
        bus.CSC = 2'b00;
        chk("p0_en", 32'(bus.port_state), 32'(ps(1, 3)));
        chk("p0_en_chg", 32'(bus.state_chg), 32'h1);
`ifdef DBC_EVENT_LATCH_EN
        bus.evt_clr = 2'b01;  // clear coincides with state_chg: set wins
        step(1);
        chk("evt_setwins", 32'(bus.evt_pending), 32'h1);
        step(1);
        chk("evt_clr0", 32'(bus.evt_pending), 0);
        bus.evt_clr = 2'b00;
`else
        step(2);
`endif
        bus.set_config_succesful = 2'b01;
        step(1);
        bus.set_config_succesful = 2'b00;
        chk("p0_cfg", 32'(bus.port_state), 32'(ps(1, 6)));
        chk("p0_cfg_run_lag", 32'(bus.dbc_run), 0);
        step(1);
        chk("p0_run", 32'(bus.dbc_run), 1);

        // Port1: ENABLED with no events for 8 cycles -> ERROR by watchdog
        bus.CSC = 2'b10;
        step(1);
        bus.CSC = 2'b00;
        chk("p1_en", 32'(bus.port_state), 32'(ps(3, 6)));
        step(7);
        chk("p1_en_hold", 32'(bus.port_state), 32'(ps(3, 6)));
        chk("p1_no_tmo", 32'(bus.timeout_err), 0);
        step(1);
        chk("p1_tmo_state", 32'(bus.port_state), 32'(ps(5, 6)));
        chk("p1_tmo_err", 32'(bus.timeout_err), 32'h2);
        chk("p1_tmo_chg", 32'(bus.state_chg), 32'h2);
        step(1);
        chk("p1_tmo_pulse", 32'(bus.timeout_err), 0);
        chk("p1_run_hold", 32'(bus.dbc_run), 1);

        // Port1: back to ENABLED, SET_CONFIGURATION in the expiry cycle wins
        bus.CSC = 2'b10;
        step(1);
        chk("p1_disc", 32'(bus.port_state), 32'(ps(1, 6)));
        step(1);
        bus.CSC = 2'b00;
        chk("p1_en2", 32'(bus.port_state), 32'(ps(3, 6)));
        step(7);
        bus.set_config_succesful = 2'b10;
        step(1);
        bus.set_config_succesful = 2'b00;
        chk("p1_cfg_edge", 32'(bus.port_state), 32'(ps(6, 6)));
        chk("p1_cfg_no_tmo", 32'(bus.timeout_err), 0);

        // Port0: bus reset, no PRC for 4 cycles -> ERROR
        bus.Reset_rcvd = 2'b01;
        step(1);
        bus.Reset_rcvd = 2'b00;
        chk("p0_rst", 32'(bus.port_state), 32'(ps(6, 4)));
        step(3);
        chk("p0_rst_hold", 32'(bus.port_state), 32'(ps(6, 4)));
        step(1);
        chk("p0_rst_tmo", 32'(bus.port_state), 32'(ps(6, 5)));
        chk("p0_rst_tmo_err", 32'(bus.timeout_err), 32'h1);

        // Port0: bus reset again, PRC on cycle 2 -> ENABLED
        bus.Reset_rcvd = 2'b01;
        step(1);
        bus.Reset_rcvd = 2'b00;
        chk("p0_rst2", 32'(bus.port_state), 32'(ps(6, 4)));
        step(1);
        bus.PRC = 2'b01;
        step(1);
        bus.PRC = 2'b00;
        chk("p0_prc", 32'(bus.port_state), 32'(ps(6, 3)));
        chk("p0_prc_no_tmo", 32'(bus.timeout_err), 0);
        bus.set_config_succesful = 2'b01;
        step(1);
        bus.set_config_succesful = 2'b00;
        chk("both_cfg", 32'(bus.port_state), 32'(ps(6, 6)));

        // DCE drop: both ports OFF with a simultaneous pulse
        bus.DCE = 1'b0;
        step(1);
        chk("dce0_state", 32'(bus.port_state), 32'(ps(0, 0)));
        chk("dce0_chg", 32'(bus.state_chg), 32'h3);
        step(1);
        chk("dce0_run", 32'(bus.dbc_run), 0);
        chk("dce0_chg_off", 32'(bus.state_chg), 0);

        // Both ports to RESETTING, then async reset without a clock edge
        bus.DCE = 1'b1;
        step(1);
        bus.CSC = 2'b11;
        step(1);
        bus.CSC = 2'b00;
        chk("both_en", 32'(bus.port_state), 32'(ps(3, 3)));
        bus.Reset_rcvd = 2'b11;
        step(1);
        bus.Reset_rcvd = 2'b00;
        chk("both_rst", 32'(bus.port_state), 32'(ps(4, 4)));
        chk("both_rst_chg", 32'(bus.state_chg), 32'h3);
        #2 reset_n = 1'b0;
        #1;
        chk("async_state", 32'(bus.port_state), 32'(ps(0, 0)));
        chk("async_chg", 32'(bus.state_chg), 0);
        chk("async_tmo", 32'(bus.timeout_err), 0);
        chk("async_run", 32'(bus.dbc_run), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
